// File: rtl/ets_pkg.sv
// Shared state encoding and default widths for the ETS multi-channel accumulator.
package ets_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    CLR  = 2'b11
  } ets_state_e;

  localparam int ETS_CNT_W = 32;
  localparam int ETS_SEG_W = 8;

endpackage

// File: rtl/ets_seg_counter.sv
// Up-counter built from SEG_W-bit segments; a segment steps only when every lower
// segment is all-ones. Synchronous clear wins over enable.
module ets_seg_counter
  import ets_pkg::*;
#(
  parameter int CNT_W = ETS_CNT_W,
  parameter int SEG_W = ETS_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam int NSEG = CNT_W / SEG_W;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             run;

  always_comb begin
    count_d = count_q;
    run     = en;
    for (int k = 0; k < NSEG; k++) begin
      if (run) begin
        count_d[k*SEG_W +: SEG_W] = count_q[k*SEG_W +: SEG_W] + SEG_W'(1);
      end
      run = run & (&count_q[k*SEG_W +: SEG_W]);
    end
    if (clr) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ets_multi_accum.sv
// Multi-channel equivalent-time-sampling accumulator: counts per-channel hits over a
// window of enabled slots. Optional macro ETS_MULTI_ACCUM_SNAPSHOT_EN holds results until the next DONE.
//
// state | meaning
// IDLE  | waiting for start; latches window length on acceptance
// BUSY  | counting enabled slots and per-channel hits
// DONE  | window complete, counts frozen until start drops
// CLR   | one cycle clearing counters and zero_win
module ets_multi_accum
  import ets_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = ETS_CNT_W,
  parameter int SEG_W = ETS_SEG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    average,
  input  logic [CH-1:0]       data_in,
  input  logic                enc,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                zero_win,
  output logic [CNT_W-1:0]    slot_count,
  output logic [CH*CNT_W-1:0] data
);

  ets_state_e          state_q, state_d;
  logic [CNT_W-1:0]    avg_q, avg_d;
  logic                zero_win_q, zero_win_d;
  logic                slot_en;
  logic [CH-1:0]       ch_en;
  logic                cnt_clr;
  logic                last_slot;
  logic [CNT_W-1:0]    slot_cnt;
  logic [CH*CNT_W-1:0] live_data;

  ets_seg_counter #(.CNT_W(CNT_W), .SEG_W(SEG_W)) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (slot_en),
    .clr   (cnt_clr),
    .count (slot_cnt)
  );

  for (genvar i = 0; i < CH; i++) begin : g_ch
    ets_seg_counter #(.CNT_W(CNT_W), .SEG_W(SEG_W)) u_ch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (ch_en[i]),
      .clr   (cnt_clr),
      .count (live_data[i*CNT_W +: CNT_W])
    );
  end

  // avg_q is never zero in BUSY, so the subtraction cannot wrap there
  assign last_slot = (slot_cnt == avg_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    avg_d      = avg_q;
    zero_win_d = zero_win_q;
    slot_en    = 1'b0;
    ch_en      = '0;
    cnt_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          avg_d = average;
          if (average == '0) begin
            zero_win_d = 1'b1;
            state_d    = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!start) begin
          state_d = CLR;
        end else if (enc) begin
          slot_en = 1'b1;
          ch_en   = data_in;
          if (last_slot) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d = CLR;
        end
      end
      CLR: begin
        cnt_clr    = 1'b1;
        zero_win_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      avg_q      <= '0;
      zero_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      avg_q      <= avg_d;
      zero_win_q <= zero_win_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign done     = (state_q == DONE);
  assign zero_win = zero_win_q;

`ifdef ETS_MULTI_ACCUM_SNAPSHOT_EN
  logic [CH*CNT_W-1:0] snap_data_q;
  logic [CNT_W-1:0]    snap_slot_q;
  logic                snap_take;

  // Capture includes the final slot, which the live counters only show a cycle later
  assign snap_take = (state_q == BUSY) && start && enc && last_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data_q <= '0;
      snap_slot_q <= '0;
    end else if (snap_take) begin
      snap_slot_q <= avg_q;
      for (int i = 0; i < CH; i++) begin
        snap_data_q[i*CNT_W +: CNT_W] <= live_data[i*CNT_W +: CNT_W] + CNT_W'(data_in[i]);
      end
    end
  end

  assign data       = snap_data_q;
  assign slot_count = snap_slot_q;
`else
  assign data       = live_data;
  assign slot_count = slot_cnt;
`endif

endmodule
